// File: rtl/tqvp_sprite_compositor.sv
// Two-sprite pixel compositor: latches sprite attributes per frame and renders
// RGB222 with priority, flip and collision detection, 2-cycle aligned with the syncs.
module tqvp_sprite_compositor #(
    parameter logic [5:0] BG_RGB         = 6'b000000,
    parameter bit         LATCH_ON_VSYNC = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [10:0]  pix_x,
    input  logic [9:0]   pix_y,
    input  logic         visible_in,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic [7:0]   spr0_xw,
    input  logic [7:0]   spr0_yw,
    input  logic [7:0]   spr1_xw,
    input  logic [7:0]   spr1_yw,
    input  logic [2:0]   spr0_ctrl,
    input  logic [2:0]   spr1_ctrl,
    input  logic [143:0] spr0_bmp,
    input  logic [143:0] spr1_bmp,
    input  logic         coll_clear,
    output logic [5:0]   rgb_out,
    output logic         hsync_out,
    output logic         vsync_out,
    output logic         de_out,
    output logic         collision
);

    function automatic logic [5:0] pal(input logic [1:0] sel);
        case (sel)
            2'd0:    pal = 6'b000011;
            2'd1:    pal = 6'b001100;
            2'd2:    pal = 6'b110000;
            default: pal = 6'b111111;
        endcase
    endfunction

    function automatic logic bmp_bit(input logic [143:0] bmp, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic flip);
        logic [3:0] col;
        logic [7:0] idx;
        col = flip ? (4'd11 - dx) : dx;
        idx = ({4'd0, dy} * 8'd12) + {4'd0, col};
        bmp_bit = (idx < 8'd144) ? bmp[idx] : 1'b0;
    endfunction

    logic         vs_d;
    logic         load;
    logic [7:0]   act_x0, act_y0, act_x1, act_y1;
    logic [2:0]   act_ctrl0, act_ctrl1;
    logic [143:0] act_bmp0, act_bmp1;

    assign load = LATCH_ON_VSYNC ? (vsync_in & ~vs_d) : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d      <= 1'b0;
            act_x0    <= '0;
            act_y0    <= '0;
            act_x1    <= '0;
            act_y1    <= '0;
            act_ctrl0 <= '0;
            act_ctrl1 <= '0;
            act_bmp0  <= '0;
            act_bmp1  <= '0;
        end else begin
            vs_d <= vsync_in;
            if (load) begin
                act_x0    <= spr0_xw;
                act_y0    <= spr0_yw;
                act_x1    <= spr1_xw;
                act_y1    <= spr1_yw;
                act_ctrl0 <= spr0_ctrl;
                act_ctrl1 <= spr1_ctrl;
                act_bmp0  <= spr0_bmp;
                act_bmp1  <= spr1_bmp;
            end
        end
    end

    // Stage 1: sprite-relative offsets. The 9-bit difference goes negative left/above
    // a sprite, so a sprite near the right or bottom edge is clipped instead of wrapping.
    logic [7:0] lx, ly;
    logic [8:0] dx0, dy0, dx1, dy1;
    logic       unused_pix;

    assign lx  = pix_x[9:2];
    assign ly  = pix_y[9:2];
    assign dx0 = {1'b0, lx} - {1'b0, act_x0};
    assign dy0 = {1'b0, ly} - {1'b0, act_y0};
    assign dx1 = {1'b0, lx} - {1'b0, act_x1};
    assign dy1 = {1'b0, ly} - {1'b0, act_y1};
    assign unused_pix = ^{pix_x[10], pix_x[1:0], pix_y[1:0]};

    logic       in0_p1, in1_p1, vis_p1, hs_p1, vs_p1;
    logic [3:0] dx0_p1, dy0_p1, dx1_p1, dy1_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in0_p1 <= 1'b0;
            in1_p1 <= 1'b0;
            dx0_p1 <= '0;
            dy0_p1 <= '0;
            dx1_p1 <= '0;
            dy1_p1 <= '0;
            vis_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else begin
            in0_p1 <= (dx0 < 9'd12) && (dy0 < 9'd12);
            in1_p1 <= (dx1 < 9'd12) && (dy1 < 9'd12);
            dx0_p1 <= dx0[3:0];
            dy0_p1 <= dy0[3:0];
            dx1_p1 <= dx1[3:0];
            dy1_p1 <= dy1[3:0];
            vis_p1 <= visible_in;
            hs_p1  <= hsync_in;
            vs_p1  <= vsync_in;
        end
    end

    // Stage 2: bitmap lookup, priority mux and collision.
    logic p0, p1;

    assign p0 = vis_p1 & in0_p1 & bmp_bit(act_bmp0, dx0_p1, dy0_p1, act_ctrl0[2]);
    assign p1 = vis_p1 & in1_p1 & bmp_bit(act_bmp1, dx1_p1, dy1_p1, act_ctrl1[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (!vis_p1)
                rgb_out <= '0;
            else if (p1)
                rgb_out <= pal(act_ctrl1[1:0]);
            else if (p0)
                rgb_out <= pal(act_ctrl0[1:0]);
            else
                rgb_out <= BG_RGB;
            hsync_out <= hs_p1;
            vsync_out <= vs_p1;
            de_out    <= vis_p1;
            collision <= (p0 & p1) | (collision & ~coll_clear);
        end
    end

endmodule
